// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register map, status bit positions and FSM states for mmio_uart
package mmio_pkg;

    localparam logic [1:0] UART_DATA    = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_DIVISOR = 2'd2;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_IDLE      = 1;
    localparam int ST_RX_VALID     = 2;
    localparam int ST_RX_OVERRUN   = 3;
    localparam int ST_RX_FRAME_ERR = 4;
    localparam int ST_COUNT_LSB    = 8;

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, first word visible on pop_data
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mmio_uart.sv
// rtl/mmio_uart.sv - memory-mapped 8N1 UART with buffered TX and single-byte RX holding register
module mmio_uart
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int DIV_RESET  = 867
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sel,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_data_w,
    input  logic [3:0]  bus_mask_w,
    output logic [31:0] bus_data_r,
    output logic        tx,
    input  logic        rx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 bus_wr, bus_rd, data_rd, fifo_push, fifo_pop;
    logic                 fifo_full, fifo_empty;
    logic [7:0]           fifo_dout;
    logic [CW-1:0]        fifo_count;
    logic [DIV_WIDTH-1:0] divisor, div_wdata, rx_half;
    logic [31:0]          rd_val;
    logic                 unused_data;

    tx_state_t            tx_state, tx_state_n;
    logic [DIV_WIDTH-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]           tx_bit, tx_bit_n;
    logic [7:0]           tx_shift, tx_shift_n;

    rx_state_t            rx_state, rx_state_n;
    logic [DIV_WIDTH-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]           rx_bit, rx_bit_n;
    logic [7:0]           rx_shift, rx_shift_n;
    logic                 rx_meta, rx_sync, rx_prev;
    logic                 rx_deliver, rx_frame_bad;
    logic [7:0]           rx_data;
    logic                 rx_valid, rx_overrun, rx_frame_err;

    assign bus_wr      = sel && (bus_mask_w != 4'b0000);
    assign bus_rd      = sel && (bus_mask_w == 4'b0000);
    assign data_rd     = bus_rd && (bus_addr == UART_DATA);
    assign fifo_push   = bus_wr && (bus_addr == UART_DATA) && bus_mask_w[0];
    assign rx_half     = (divisor + DIV_WIDTH'(1)) >> 1;
    assign unused_data = ^bus_data_w;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (bus_data_w[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Byte-masked merge of write data into the current divisor.
    always_comb begin
        div_wdata = divisor;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            if (bus_mask_w[i/8]) div_wdata[i] = bus_data_w[i];
        end
    end

    // TX next state: each start/data/stop slot lasts divisor+1 clocks.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        fifo_pop   = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_n = fifo_dout;
                    tx_cnt_n   = divisor;
                    tx_state_n = T_START;
                end
            end
            T_START: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n   = divisor;
                    tx_bit_n   = 3'd0;
                    tx_state_n = T_DATA;
                end else begin
                    tx_cnt_n = tx_cnt - DIV_WIDTH'(1);
                end
            end
            T_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n   = divisor;
                    tx_shift_n = tx_shift >> 1;
                    if (tx_bit == 3'd7) tx_state_n = T_STOP;
                    else                tx_bit_n   = tx_bit + 3'd1;
                end else begin
                    tx_cnt_n = tx_cnt - DIV_WIDTH'(1);
                end
            end
            default: begin
                if (tx_cnt == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tx_shift_n = fifo_dout;
                        tx_cnt_n   = divisor;
                        tx_state_n = T_START;
                    end else begin
                        tx_state_n = T_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt - DIV_WIDTH'(1);
                end
            end
        endcase
    end

    // tx decodes straight from state so reset drives the line high immediately.
    assign tx = (tx_state == T_START) ? 1'b0 :
                (tx_state == T_DATA)  ? tx_shift[0] : 1'b1;

    // TX state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
        end
    end

    // RX next state: the detection cycle counts toward the half-bit wait, so a
    // zero half-bit goes straight to data sampling.
    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = rx_cnt;
        rx_bit_n     = rx_bit;
        rx_shift_n   = rx_shift;
        rx_deliver   = 1'b0;
        rx_frame_bad = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    if (rx_half == '0) begin
                        rx_cnt_n   = divisor;
                        rx_bit_n   = 3'd0;
                        rx_state_n = R_DATA;
                    end else begin
                        rx_cnt_n   = rx_half - DIV_WIDTH'(1);
                        rx_state_n = R_START;
                    end
                end
            end
            R_START: begin
                if (rx_cnt == '0) begin
                    if (rx_sync) begin
                        rx_state_n = R_IDLE;
                    end else begin
                        rx_cnt_n   = divisor;
                        rx_bit_n   = 3'd0;
                        rx_state_n = R_DATA;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - DIV_WIDTH'(1);
                end
            end
            R_DATA: begin
                if (rx_cnt == '0) begin
                    rx_cnt_n   = divisor;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = R_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt - DIV_WIDTH'(1);
                end
            end
            default: begin
                if (rx_cnt == '0) begin
                    rx_deliver   = rx_sync;
                    rx_frame_bad = !rx_sync;
                    rx_state_n   = R_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt - DIV_WIDTH'(1);
                end
            end
        endcase
    end

    // RX synchronizer, edge history and state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // Read mux for the selected register.
    always_comb begin
        rd_val = '0;
        case (bus_addr)
            UART_DATA: rd_val[7:0] = rx_data;
            UART_STATUS: begin
                rd_val[ST_TX_FULL]            = fifo_full;
                rd_val[ST_TX_IDLE]            = fifo_empty && (tx_state == T_IDLE);
                rd_val[ST_RX_VALID]           = rx_valid;
                rd_val[ST_RX_OVERRUN]         = rx_overrun;
                rd_val[ST_RX_FRAME_ERR]       = rx_frame_err;
                rd_val[ST_COUNT_LSB +: CW]    = fifo_count;
            end
            UART_DIVISOR: rd_val[DIV_WIDTH-1:0] = divisor;
            default: rd_val = '0;
        endcase
    end

    // Registers, RX holding byte and sticky flags; new errors win over a same-cycle clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            divisor      <= DIV_WIDTH'(DIV_RESET);
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            bus_data_r   <= '0;
        end else begin
            if (bus_wr && (bus_addr == UART_DIVISOR)) divisor <= div_wdata;
            if (bus_wr && (bus_addr == UART_STATUS) && bus_mask_w[0]) begin
                if (bus_data_w[ST_RX_OVERRUN])   rx_overrun   <= 1'b0;
                if (bus_data_w[ST_RX_FRAME_ERR]) rx_frame_err <= 1'b0;
            end
            if (rx_deliver && rx_valid && !data_rd) rx_overrun <= 1'b1;
            if (rx_frame_bad) rx_frame_err <= 1'b1;
            if (rx_deliver && !(rx_valid && !data_rd)) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (data_rd) begin
                rx_valid <= 1'b0;
            end
            bus_data_r <= bus_rd ? rd_val : 32'h0;
        end
    end

endmodule
